// File: rtl/tile_dispatch_scheduler.sv
// Converts per-tile routing decisions into tile-ID work items and queues them for the CNN and SNN engines.
// A full target queue can spill to the other engine; when that is not possible, the tile is dropped and counted.
module tile_dispatch_scheduler #(
    parameter int TILE_ID_WIDTH   = 11,
    parameter int TILES_PER_FRAME = 1200,
    parameter int QUEUE_DEPTH     = 8,
    parameter bit ALLOW_SPILL     = 1'b1,
    parameter int DEPTH_WIDTH     = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iFrameStart,
    input  logic                     iRouteToCnn,
    input  logic                     iDecisionValid,
    output logic [TILE_ID_WIDTH-1:0] oCnnTileId,
    output logic                     oCnnValid,
    input  logic                     iCnnReady,
    output logic [TILE_ID_WIDTH-1:0] oSnnTileId,
    output logic                     oSnnValid,
    input  logic                     iSnnReady,
    output logic [DEPTH_WIDTH-1:0]   oCnnDepth,
    output logic [DEPTH_WIDTH-1:0]   oSnnDepth,
    output logic                     oSpill,
    output logic                     oDrop,
    output logic [15:0]              oDropCount
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    logic [TILE_ID_WIDTH-1:0] tile_idx;
    logic [TILE_ID_WIDTH-1:0] dec_id;
    logic [TILE_ID_WIDTH-1:0] next_idx;

    logic [TILE_ID_WIDTH-1:0] cnn_mem [QUEUE_DEPTH];
    logic [TILE_ID_WIDTH-1:0] snn_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]         cnn_rd_ptr, cnn_wr_ptr, snn_rd_ptr, snn_wr_ptr;
    logic [DEPTH_WIDTH-1:0]   cnn_count, snn_count;

    logic cnn_full, snn_full, cnn_pop, snn_pop;
    logic push_cnn, push_snn, spill, drop;
    logic target_full, other_full;

    assign cnn_full = (cnn_count == DEPTH_WIDTH'(QUEUE_DEPTH));
    assign snn_full = (snn_count == DEPTH_WIDTH'(QUEUE_DEPTH));
    assign cnn_pop  = (cnn_count != '0) && iCnnReady;
    assign snn_pop  = (snn_count != '0) && iSnnReady;

    // A frame start coinciding with a decision hands that decision index 0.
    assign dec_id   = iFrameStart ? '0 : tile_idx;
    assign next_idx = (dec_id == TILE_ID_WIDTH'(TILES_PER_FRAME - 1)) ? '0 : dec_id + TILE_ID_WIDTH'(1);

    assign target_full = iRouteToCnn ? cnn_full : snn_full;
    assign other_full  = iRouteToCnn ? snn_full : cnn_full;

    always_comb begin
        push_cnn = 1'b0;
        push_snn = 1'b0;
        spill    = 1'b0;
        drop     = 1'b0;
        if (iDecisionValid) begin
            if (!target_full) begin
                push_cnn = iRouteToCnn;
                push_snn = !iRouteToCnn;
            end else if (ALLOW_SPILL && !other_full) begin
                push_cnn = !iRouteToCnn;
                push_snn = iRouteToCnn;
                spill    = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Storage is deliberately not reset so it can map to distributed RAM.
    always_ff @(posedge iClk) begin
        if (iRst && push_cnn) cnn_mem[cnn_wr_ptr] <= dec_id;
        if (iRst && push_snn) snn_mem[snn_wr_ptr] <= dec_id;
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            tile_idx   <= '0;
            cnn_rd_ptr <= '0;
            cnn_wr_ptr <= '0;
            snn_rd_ptr <= '0;
            snn_wr_ptr <= '0;
            cnn_count  <= '0;
            snn_count  <= '0;
            oSpill     <= 1'b0;
            oDrop      <= 1'b0;
            oDropCount <= '0;
        end else begin
            if (iDecisionValid)   tile_idx <= next_idx;
            else if (iFrameStart) tile_idx <= '0;

            if (push_cnn) cnn_wr_ptr <= cnn_wr_ptr + PTR_W'(1);
            if (cnn_pop)  cnn_rd_ptr <= cnn_rd_ptr + PTR_W'(1);
            if (push_cnn && !cnn_pop)      cnn_count <= cnn_count + DEPTH_WIDTH'(1);
            else if (!push_cnn && cnn_pop) cnn_count <= cnn_count - DEPTH_WIDTH'(1);

            if (push_snn) snn_wr_ptr <= snn_wr_ptr + PTR_W'(1);
            if (snn_pop)  snn_rd_ptr <= snn_rd_ptr + PTR_W'(1);
            if (push_snn && !snn_pop)      snn_count <= snn_count + DEPTH_WIDTH'(1);
            else if (!push_snn && snn_pop) snn_count <= snn_count - DEPTH_WIDTH'(1);

            oSpill <= spill;
            oDrop  <= drop;
            if (drop && oDropCount != 16'hFFFF) oDropCount <= oDropCount + 16'd1;
        end
    end

    assign oCnnValid  = (cnn_count != '0);
    assign oSnnValid  = (snn_count != '0);
    assign oCnnTileId = oCnnValid ? cnn_mem[cnn_rd_ptr] : '0;
    assign oSnnTileId = oSnnValid ? snn_mem[snn_rd_ptr] : '0;
    assign oCnnDepth  = cnn_count;
    assign oSnnDepth  = snn_count;

endmodule

// File: tb/tb_tile_dispatch_scheduler.sv
// Directed bench for tile_dispatch_scheduler. It drives a spilling instance (a) and a dropping instance (b) from shared inputs.
module tb_tile_dispatch_scheduler;

    logic iClk = 1'b0;
    logic iRst, iFrameStart, iRouteToCnn, iDecisionValid, iCnnReady, iSnnReady;

    logic [10:0] a_cnn_id, a_snn_id, b_cnn_id, b_snn_id;
    logic        a_cnn_v, a_snn_v, b_cnn_v, b_snn_v;
    logic [3:0]  a_cnn_d, a_snn_d, b_cnn_d, b_snn_d;
    logic        a_spill, a_drop, b_spill, b_drop;
    logic [15:0] a_dcnt, b_dcnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 iClk = ~iClk;

    tile_dispatch_scheduler #(.ALLOW_SPILL(1'b1)) dut_a (
        .iClk(iClk), .iRst(iRst), .iFrameStart(iFrameStart), .iRouteToCnn(iRouteToCnn),
        .iDecisionValid(iDecisionValid),
        .oCnnTileId(a_cnn_id), .oCnnValid(a_cnn_v), .iCnnReady(iCnnReady),
        .oSnnTileId(a_snn_id), .oSnnValid(a_snn_v), .iSnnReady(iSnnReady),
        .oCnnDepth(a_cnn_d), .oSnnDepth(a_snn_d), .oSpill(a_spill), .oDrop(a_drop),
        .oDropCount(a_dcnt)
    );

    tile_dispatch_scheduler #(.ALLOW_SPILL(1'b0)) dut_b (
        .iClk(iClk), .iRst(iRst), .iFrameStart(iFrameStart), .iRouteToCnn(iRouteToCnn),
        .iDecisionValid(iDecisionValid),
        .oCnnTileId(b_cnn_id), .oCnnValid(b_cnn_v), .iCnnReady(iCnnReady),
        .oSnnTileId(b_snn_id), .oSnnValid(b_snn_v), .iSnnReady(iSnnReady),
        .oCnnDepth(b_cnn_d), .oSnnDepth(b_snn_d), .oSpill(b_spill), .oDrop(b_drop),
        .oDropCount(b_dcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic decide(input logic to_cnn);
        iDecisionValid = 1'b1;
        iRouteToCnn    = to_cnn;
        tick();
        iDecisionValid = 1'b0;
    endtask

    task automatic frame_start();
        iFrameStart = 1'b1;
        tick();
        iFrameStart = 1'b0;
    endtask

    initial begin
        iRst = 1'b0; iFrameStart = 1'b0; iRouteToCnn = 1'b0; iDecisionValid = 1'b0;
        iCnnReady = 1'b0; iSnnReady = 1'b0;
        #2;
        tick(); tick();
        check("rst_cnn_valid", a_cnn_v, 0);
        check("rst_snn_valid", a_snn_v, 0);
        check("rst_cnn_depth", a_cnn_d, 0);
        check("rst_snn_depth", b_snn_d, 0);
        check("rst_cnn_id", a_cnn_id, 0);
        check("rst_pulses", {a_spill, a_drop, b_spill, b_drop}, 0);
        check("rst_dropcnt", b_dcnt, 0);

        // basic routing, both engines always ready
        iRst = 1'b1; iCnnReady = 1'b1; iSnnReady = 1'b1;
        decide(1'b1);
        check("basic_cnn_v0", a_cnn_v, 1);
        check("basic_cnn_id0", a_cnn_id, 0);
        decide(1'b0);
        check("basic_cnn_popped", a_cnn_v, 0);
        check("basic_snn_v1", a_snn_v, 1);
        check("basic_snn_id1", a_snn_id, 1);
        decide(1'b1);
        check("basic_cnn_id2", a_cnn_id, 2);
        check("basic_snn_popped", a_snn_v, 0);
        tick();
        check("basic_cnn_depth0", a_cnn_d, 0);
        check("basic_snn_depth0", a_snn_d, 0);

        // backpressure and ordering
        frame_start();
        iCnnReady = 1'b0;
        for (int i = 0; i < 5; i++) decide(1'b1);
        check("bp_depth5", a_cnn_d, 5);
        check("bp_head_held", a_cnn_id, 0);
        tick();
        check("bp_head_still", a_cnn_id, 0);
        iCnnReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_order_v", a_cnn_v, 1);
            check("bp_order_id", a_cnn_id, i);
            tick();
        end
        check("bp_drained_v", a_cnn_v, 0);
        check("bp_drained_d", a_cnn_d, 0);

        // spill vs drop on a full CNN queue
        frame_start();
        iCnnReady = 1'b0; iSnnReady = 1'b0;
        for (int i = 0; i < 8; i++) decide(1'b1);
        check("sp_cnn_full", a_cnn_d, 8);
        check("sp_no_spill_yet", a_spill, 0);
        decide(1'b1);
        check("sp_a_spill", a_spill, 1);
        check("sp_a_drop", a_drop, 0);
        check("sp_a_cnn_d", a_cnn_d, 8);
        check("sp_a_snn_d", a_snn_d, 1);
        check("sp_a_snn_id", a_snn_id, 8);
        check("sp_a_dcnt", a_dcnt, 0);
        check("sp_b_drop", b_drop, 1);
        check("sp_b_spill", b_spill, 0);
        check("sp_b_dcnt", b_dcnt, 1);
        check("sp_b_snn_d", b_snn_d, 0);
        tick();
        check("sp_pulse_once", {a_spill, b_drop}, 0);

        // full queue pops in the same cycle: push is still refused
        iCnnReady = 1'b1;
        decide(1'b1);
        check("fp_a_spill", a_spill, 1);
        check("fp_a_cnn_d", a_cnn_d, 7);
        check("fp_a_snn_d", a_snn_d, 2);
        check("fp_b_drop", b_drop, 1);
        check("fp_b_dcnt", b_dcnt, 2);
        check("fp_b_cnn_d", b_cnn_d, 7);
        iSnnReady = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("fp_drain_a", {a_cnn_d, a_snn_d}, 0);
        check("fp_drain_b", {b_cnn_d, b_snn_d}, 0);

        // index wrap across a full frame
        frame_start();
        for (int i = 0; i < 1200; i++) begin
            decide(1'b1);
            check("wrap_id", a_cnn_id, i);
        end
        decide(1'b1);
        check("wrap_to_0", a_cnn_id, 0);
        for (int i = 0; i < 36; i++) decide(1'b1);
        check("fs_idx36", a_cnn_id, 36);
        iFrameStart = 1'b1;
        decide(1'b1);
        iFrameStart = 1'b0;
        check("fs_coincident_id0", a_cnn_id, 0);
        decide(1'b0);
        check("fs_next_id1", a_snn_id, 1);
        tick();

        // reset mid-operation; inputs during reset are ignored
        iCnnReady = 1'b0; iSnnReady = 1'b0;
        for (int i = 0; i < 3; i++) decide(1'b1);
        for (int i = 0; i < 2; i++) decide(1'b0);
        check("mr_cnn_d3", a_cnn_d, 3);
        check("mr_snn_d2", b_snn_d, 2);
        iRst = 1'b0; iCnnReady = 1'b1; iSnnReady = 1'b1;
        decide(1'b1);
        check("mr_valids", {a_cnn_v, a_snn_v, b_cnn_v, b_snn_v}, 0);
        check("mr_depths", {a_cnn_d, a_snn_d}, 0);
        check("mr_ids", {a_cnn_id, a_snn_id}, 0);
        check("mr_b_dcnt", b_dcnt, 0);
        iRst = 1'b1; iCnnReady = 1'b0; iSnnReady = 1'b0;
        decide(1'b1);
        check("mr_first_id0", a_cnn_id, 0);
        check("mr_first_d1", a_cnn_d, 1);

        // drop counter saturation
        for (int i = 0; i < 7; i++) decide(1'b1);
        check("sat_cnn_full", b_cnn_d, 8);
        for (int i = 0; i < 65540; i++) begin
            decide(1'b1);
            if (i == 65533) check("sat_b_65534", b_dcnt, 65534);
        end
        check("sat_b_hold", b_dcnt, 65535);
        check("sat_a_count", a_dcnt, 65532);
        check("sat_a_snn_full", a_snn_d, 8);
        tick();
        check("sat_b_after", b_dcnt, 65535);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
